prio_encoder_rr: RTL and testbench

- Parametrised, registered N-to-log2(N) priority encoder; successor to the fixed 8-to-3 combinational encoder.
- Adds a selectable round-robin mode, a one-hot grant output and a valid/ready output handshake.
- Sits between request sources (interrupt lines, arbiter requesters) and a single downstream consumer.
- The consumer takes one encoded index per handshake.

---
 rtl/prio_encoder_rr_if.sv | 24 ++
 rtl/prio_encoder_rr.sv | 78 +++++++
 tb/tb_prio_encoder_rr.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/prio_encoder_rr_if.sv
// Request/handshake bundle for prio_encoder_rr: requests and back-pressure in,
// encoded index, one-hot grant and round-robin pointer out.
interface prio_encoder_rr_if #(
  parameter int N = 8,
  parameter int W = 3
);
  logic         en;
  logic [N-1:0] req;
  logic         out_ready;
  logic         out_valid;
  logic [W-1:0] idx;
  logic [N-1:0] grant;
  logic [W-1:0] ptr;

  modport master (
    output en, req, out_ready,
    input  out_valid, idx, grant, ptr
  );

  modport slave (
    input  en, req, out_ready,
    output out_valid, idx, grant, ptr
  );
endinterface

// File: rtl/prio_encoder_rr.sv
// Registered N-to-log2(N) priority encoder with optional round-robin priority,
// one-hot grant and a single-entry valid/ready output slot.
module prio_encoder_rr #(
  parameter int N    = 8,
  parameter int W    = 3,
  parameter int MODE = 0
) (
  input  logic            clk,
  input  logic            rst,
  prio_encoder_rr_if.slave bus
);

  if (N < 2 || N > 256 || W != $clog2(N) || (MODE != 0 && MODE != 1)) begin : g_param_check
    $error("prio_encoder_rr: illegal parameter combination");
  end

  logic         any;
  logic         found_hi;
  logic [W-1:0] fixed_win;
  logic [W-1:0] lo_win;
  logic [W-1:0] hi_win;
  logic [W-1:0] win;
  logic [W-1:0] nxt_ptr;
  logic         free;

  // Round-robin winner is the lowest set bit at or above ptr, falling back to
  // the lowest set bit overall; that is the rotating scan without a rotator.
  always_comb begin
    any       = 1'b0;
    found_hi  = 1'b0;
    fixed_win = '0;
    lo_win    = '0;
    hi_win    = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (bus.req[i]) begin
        if (!any) begin
          lo_win = W'(i);
        end
        if (!found_hi && i >= 32'(bus.ptr)) begin
          found_hi = 1'b1;
          hi_win   = W'(i);
        end
        any       = 1'b1;
        fixed_win = W'(i);
      end
    end
    if (MODE == 0) begin
      win = fixed_win;
    end else begin
      win = found_hi ? hi_win : lo_win;
    end
    nxt_ptr = (win == W'(N - 1)) ? '0 : win + W'(1);
  end

  assign free = !bus.out_valid || bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.idx       <= '0;
      bus.grant     <= '0;
      bus.ptr       <= '0;
    end else if (free) begin
      if (bus.en && any) begin
        bus.out_valid <= 1'b1;
        bus.idx       <= win;
        bus.grant     <= N'(1) << win;
        if (MODE == 1) begin
          bus.ptr <= nxt_ptr;
        end
      end else begin
        bus.out_valid <= 1'b0;
        bus.grant     <= '0;
      end
    end
  end

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Scoreboard bench for prio_encoder_rr: three instances (N=8 fixed, N=8 RR,
// N=5 RR) share one random/directed stimulus stream and one reference model.
module tb_prio_encoder_rr;

  logic       clk = 1'b0;
  logic       rst;
  logic       en_s;
  logic [7:0] req_s;
  logic       rdy_s;

  always #5 clk = ~clk;

  prio_encoder_rr_if #(.N(8), .W(3)) b0 ();
  prio_encoder_rr_if #(.N(8), .W(3)) b1 ();
  prio_encoder_rr_if #(.N(5), .W(3)) b2 ();

  assign b0.en = en_s;  assign b0.req = req_s;      assign b0.out_ready = rdy_s;
  assign b1.en = en_s;  assign b1.req = req_s;      assign b1.out_ready = rdy_s;
  assign b2.en = en_s;  assign b2.req = req_s[4:0]; assign b2.out_ready = rdy_s;

  prio_encoder_rr #(.N(8), .W(3), .MODE(0)) u0 (.clk(clk), .rst(rst), .bus(b0));
  prio_encoder_rr #(.N(8), .W(3), .MODE(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
  prio_encoder_rr #(.N(5), .W(3), .MODE(1)) u2 (.clk(clk), .rst(rst), .bus(b2));

  typedef struct {
    int idx;
    int ptr;
  } exp_t;

  int   nn [3] = '{8, 8, 5};
  int   md [3] = '{0, 1, 1};
  bit   mvalid [3];
  int   mptr [3];
  int   midx [3];
  exp_t sbq [3][$];
  int   log_q [3][$];
  int   checks = 0;
  int   failures = 0;
  bit   armed = 1'b0;

  task automatic check(string name, logic [31:0] act, int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Reference winner: walk the requesters in priority order.
  function automatic int winner(int d);
    for (int k = 0; k < nn[d]; k++) begin
      int j;
      j = (md[d] == 0) ? nn[d] - 1 - k : (mptr[d] + k) % nn[d];
      if (req_s[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_edge();
    for (int d = 0; d < 3; d++) begin
      if (rst) begin
        mvalid[d] = 1'b0;
        mptr[d]   = 0;
        midx[d]   = 0;
        sbq[d].delete();
        armed     = 1'b1;
      end else if (!mvalid[d] || rdy_s) begin
        int w;
        w = winner(d);
        if (en_s && w >= 0) begin
          exp_t e;
          mvalid[d] = 1'b1;
          midx[d]   = w;
          if (md[d] == 1) mptr[d] = (w == nn[d] - 1) ? 0 : w + 1;
          e.idx = w;
          e.ptr = mptr[d];
          sbq[d].push_back(e);
        end else begin
          mvalid[d] = 1'b0;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(int n);
    en_s  = 1'b0;
    rdy_s = 1'b1;
    repeat (n) tick();
  endtask

  task automatic clear_logs();
    for (int d = 0; d < 3; d++) log_q[d].delete();
  endtask

  task automatic check_log(int d, string e, string name);
    check({name, ".len"}, 32'(log_q[d].size()), e.len());
    for (int i = 0; i < e.len() && i < log_q[d].size(); i++)
      check(name, 32'(log_q[d][i]), int'(e[i]) - 48);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Monitor: compares whatever the DUTs present against the scoreboard head,
  // popping on each completed handshake.
  initial begin
    logic [31:0] v [3];
    logic [31:0] ix [3];
    logic [31:0] gr [3];
    logic [31:0] pt [3];
    forever begin
      @(negedge clk);
      if (armed) begin
        v[0] = 32'(b0.out_valid); ix[0] = 32'(b0.idx); gr[0] = 32'(b0.grant); pt[0] = 32'(b0.ptr);
        v[1] = 32'(b1.out_valid); ix[1] = 32'(b1.idx); gr[1] = 32'(b1.grant); pt[1] = 32'(b1.ptr);
        v[2] = 32'(b2.out_valid); ix[2] = 32'(b2.idx); gr[2] = 32'(b2.grant); pt[2] = 32'(b2.ptr);
        for (int d = 0; d < 3; d++) begin
          check($sformatf("u%0d.valid", d), v[d], int'(sbq[d].size() != 0));
          if (sbq[d].size() != 0) begin
            exp_t e;
            e = sbq[d][0];
            check($sformatf("u%0d.idx", d), ix[d], e.idx);
            check($sformatf("u%0d.grant", d), gr[d], 1 << e.idx);
            check($sformatf("u%0d.ptr", d), pt[d], e.ptr);
            if (rdy_s) begin
              void'(sbq[d].pop_front());
              log_q[d].push_back(int'(ix[d]));
            end
          end else begin
            check($sformatf("u%0d.idle_grant", d), gr[d], 0);
            check($sformatf("u%0d.idle_idx", d), ix[d], midx[d]);
            check($sformatf("u%0d.idle_ptr", d), pt[d], mptr[d]);
          end
        end
      end
    end
  end

  initial begin
    rst   = 1'b1;
    en_s  = 1'b1;
    rdy_s = 1'b1;
    req_s = 8'b0010_1100;
    tick();
    tick();
    check("reset.valid", 32'(b0.out_valid), 0);
    check("reset.grant", 32'(b0.grant), 0);
    rst = 1'b0;
    clear_logs();
    tick();
    check("latency.idx", 32'(b0.idx), 5);
    check("latency.grant", 32'(b0.grant), 8'b0010_0000);
    for (int k = 0; k < 8; k++) begin
      req_s = 8'hFF >> k;
      tick();
    end
    req_s = 8'h00;
    tick();
    check("sweep.empty", 32'(b0.out_valid), 0);
    idle(2);
    check_log(0, "576543210", "sweep");

    clear_logs();
    en_s  = 1'b1;
    req_s = 8'h10;
    tick();
    rdy_s = 1'b0;
    req_s = 8'h80;
    repeat (3) begin
      tick();
      check("bp.hold_idx", 32'(b0.idx), 4);
      check("bp.hold_valid", 32'(b0.out_valid), 1);
    end
    rdy_s = 1'b1;
    tick();
    idle(2);
    check_log(0, "47", "bp");

    do_reset();
    clear_logs();
    en_s  = 1'b1;
    req_s = 8'hFF;
    repeat (9) tick();
    idle(2);
    check_log(1, "012345670", "rr8_all");
    check_log(2, "012340123", "rr5_all");

    do_reset();
    clear_logs();
    en_s  = 1'b1;
    req_s = 8'b1000_0001;
    repeat (4) tick();
    idle(2);
    check_log(1, "0707", "rr8_ends");

    do_reset();
    clear_logs();
    en_s  = 1'b1;
    req_s = 8'b0001_0001;
    repeat (4) tick();
    idle(2);
    check_log(2, "0404", "rr5_wrap");

    do_reset();
    en_s  = 1'b1;
    req_s = 8'h08;
    tick();
    check("dis.idx", 32'(b1.idx), 3);
    check("dis.ptr", 32'(b1.ptr), 4);
    rdy_s = 1'b0;
    en_s  = 1'b0;
    tick();
    rdy_s = 1'b1;
    tick();
    check("dis.valid", 32'(b1.out_valid), 0);
    check("dis.ptr_hold", 32'(b1.ptr), 4);
    en_s = 1'b1;
    tick();
    rdy_s = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst.valid", 32'(b1.out_valid), 0);
    check("rst.idx", 32'(b1.idx), 0);
    check("rst.grant", 32'(b1.grant), 0);
    check("rst.ptr", 32'(b1.ptr), 0);

    for (int n = 0; n < 3000; n++) begin
      rst   = ($urandom_range(0, 49) == 0);
      en_s  = ($urandom_range(0, 4) != 0);
      rdy_s = ($urandom_range(0, 9) < 7);
      case ($urandom_range(0, 3))
        0:       req_s = 8'($urandom());
        1:       req_s = 8'($urandom() & $urandom() & $urandom());
        2:       req_s = 8'(1 << $urandom_range(0, 7));
        default: req_s = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'h81;
      endcase
      tick();
    end
    rst = 1'b0;
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
